// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin cycle-level grant
// and a strobe watchdog that answers stalled strobes with a one-cycle err.
module wb_arbiter2 #(
  parameter int unsigned ADDRESS_WIDTH = 24,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0]    m0_dat_i,
  output logic [DATA_WIDTH-1:0]    m0_dat_o,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,

  input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0]    m1_dat_i,
  output logic [DATA_WIDTH-1:0]    m1_dat_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,

  output logic [ADDRESS_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  input  logic                     s_ack_i,

  output logic [1:0]               grant
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          grant_q, grant_d;
  logic                own_stb;
  logic                timeout_hit;

  // Arbitration: owner holds while its cyc is high; ties go to the master != last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i) state_d = m1_cyc_i ? StOwn1 : StIdle;
      end
      StOwn1: begin
        if (!m1_cyc_i) state_d = m0_cyc_i ? StOwn0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StOwn0 && state_q != StOwn0) last_d = 1'b0;
    if (state_d == StOwn1 && state_q != StOwn1) last_d = 1'b1;
    grant_d = {state_d == StOwn1, state_d == StOwn0};
  end

  // Slave-side mux driven by the registered grant only.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    own_stb = 1'b0;
    if (grant_q[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      own_stb = m0_stb_i;
    end else if (grant_q[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      own_stb = m1_stb_i;
    end
  end

  assign timeout_hit = (grant_q != 2'b00) && (cnt_q == CntMax);
  assign s_stb_o     = own_stb && !timeout_hit;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i && grant_q[0];
  assign m1_ack_o = s_ack_i && grant_q[1];
  // A same-cycle ack beats the timeout.
  assign m0_err_o = timeout_hit && grant_q[0] && !s_ack_i;
  assign m1_err_o = timeout_hit && grant_q[1] && !s_ack_i;

  // Watchdog never wraps: the strobe is masked once the count reaches the limit.
  always_comb begin
    cnt_d = cnt_q + CntWidth'(1);
    if (state_d != state_q || !s_stb_o || s_ack_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

endmodule
